// File: rtl/gpr_file_pkg.sv
// Shared widths and types for the integer register file and its pending-write scoreboard.
package gpr_file_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 2 ** REG_ADDR_WIDTH;
    localparam int PEND_WIDTH     = 2;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0]     reg_data_t;
    typedef logic [PEND_WIDTH-1:0]     pend_cnt_t;

    localparam reg_addr_t ZERO_REG = '0;
    localparam pend_cnt_t PEND_MAX = '1;

    // True when an enabled write port targets the given architectural register.
    function automatic logic wb_hits(input logic en, input reg_addr_t wb_addr, input reg_addr_t addr);
        return en && (wb_addr == addr);
    endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register pending-write counters: marked at issue, retired at writeback, cleared on flush.
module gpr_scoreboard
    import gpr_file_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  reg_addr_t wb_addr,
    input  logic      wb_en,
    input  logic      issue_valid,
    input  reg_addr_t issue_rd,
    input  logic      issue_wr,
    input  logic      flush,
    input  reg_addr_t rs1_addr,
    input  reg_addr_t rs2_addr,
    output logic      rs1_busy,
    output logic      rs2_busy,
    output logic      issue_full,
    output logic      sb_err
);

    pend_cnt_t cnt [NUM_REGS];
    logic      inc_req;
    logic      dec_req;
    logic      err_event;

    always_comb begin
        issue_full = (issue_rd != ZERO_REG) && (cnt[issue_rd] == PEND_MAX)
                     && !wb_hits(wb_en, wb_addr, issue_rd);
        inc_req    = issue_valid && issue_wr && !issue_full && (issue_rd != ZERO_REG);
        dec_req    = wb_en && (wb_addr != ZERO_REG);
        err_event  = (dec_req && (cnt[wb_addr] == '0)) || (issue_valid && issue_wr && issue_full);
    end

    // A read stays busy unless the only outstanding write is being bypassed this cycle.
    always_comb begin
        rs1_busy = (cnt[rs1_addr] != '0)
                   && !((cnt[rs1_addr] == pend_cnt_t'(1)) && wb_hits(wb_en, wb_addr, rs1_addr));
        rs2_busy = (cnt[rs2_addr] != '0)
                   && !((cnt[rs2_addr] == pend_cnt_t'(1)) && wb_hits(wb_en, wb_addr, rs2_addr));
    end

    // cnt[0] keeps its reset value forever, so x0 never reports busy or full.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (flush) begin
                    cnt[r] <= '0;
                end else if (inc_req && (issue_rd == reg_addr_t'(r))
                             && !(dec_req && (wb_addr == reg_addr_t'(r)))) begin
                    cnt[r] <= cnt[r] + pend_cnt_t'(1);
                end else if (dec_req && (wb_addr == reg_addr_t'(r))
                             && !(inc_req && (issue_rd == reg_addr_t'(r)))
                             && (cnt[r] != '0)) begin
                    cnt[r] <= cnt[r] - pend_cnt_t'(1);
                end
            end
            if (err_event) begin
                sb_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpr_file.sv
// Integer register file: two bypassed read ports, one write port, x0 hardwired to zero,
// with a pending-write scoreboard that drives decode stalls.
module gpr_file
    import gpr_file_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    input  logic                      wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0]     rs1_data,
    output logic [DATA_WIDTH-1:0]     rs2_data,
    input  logic                      issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    input  logic                      issue_wr,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic                      issue_full,
    input  logic                      flush,
    output logic                      sb_err
);

    reg_data_t regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != ZERO_REG)) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Writeback data is forwarded in the same cycle so decode never waits on the array.
    always_comb begin
        if (rs1_addr == ZERO_REG) begin
            rs1_data = '0;
        end else if (wb_hits(wb_en, wb_addr, rs1_addr)) begin
            rs1_data = wb_data;
        end else begin
            rs1_data = regs[rs1_addr];
        end

        if (rs2_addr == ZERO_REG) begin
            rs2_data = '0;
        end else if (wb_hits(wb_en, wb_addr, rs2_addr)) begin
            rs2_data = wb_data;
        end else begin
            rs2_data = regs[rs2_addr];
        end
    end

    gpr_scoreboard u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .wb_addr     (wb_addr),
        .wb_en       (wb_en),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_wr    (issue_wr),
        .flush       (flush),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .issue_full  (issue_full),
        .sb_err      (sb_err)
    );

endmodule
